// File: rtl/irq_ctrl_if.sv
// irq_ctrl CPU-side port bundle.
// Event pulses, mask/ack writes and status readback.
interface irq_ctrl_if;
  logic [6:0] irq;
  logic       mask_we;
  logic       ack_we;
  logic [7:0] din;
  logic       intr;
  logic [2:0] vect;
  logic [6:0] pending;
  logic [6:0] mask;
  logic       busy;
  logic       tmo;

  modport master (
    output irq, mask_we, ack_we, din,
    input  intr, vect, pending, mask, busy, tmo
  );

  modport slave (
    input  irq, mask_we, ack_we, din,
    output intr, vect, pending, mask, busy, tmo
  );
endinterface

// File: rtl/irq_ctrl.sv
// Seven-source fixed-priority interrupt controller.
// Optional ack watchdog: define IRQ_CTRL_TIMEOUT_EN.
module irq_ctrl #(
  parameter int TIMEOUT = 50000
) (
  input logic      clock,
  input logic      reset_n,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_ACK
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] pend_q;
  logic [6:0] pend_nxt;
  logic [6:0] mask_q;
  logic [6:0] mask_nxt;
  logic [2:0] vect_q;
  logic [2:0] vect_nxt;
  logic       intr_q;
  logic       intr_nxt;
  logic [6:0] grant;
  logic [2:0] code;
  logic       expire;
  logic       unused;

  assign unused = bus.din[7];

  // lowest-numbered pending source wins
  always_comb begin
    grant = pend_q & (~pend_q + 7'd1);
    code  = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pend_q[i]) code = 3'(i + 1);
    end
  end

  // next state, dispatch actions, pending/mask update
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_q;
    mask_nxt  = mask_q;
    vect_nxt  = vect_q;
    intr_nxt  = intr_q;
    unique case (state)
      IDLE: begin
        if (pend_q != 7'd0) begin
          state_nxt = DISPATCH;
          vect_nxt  = code;
          intr_nxt  = ~intr_q;
          pend_nxt  = pend_q & ~grant;
        end
      end
      DISPATCH: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.ack_we)  state_nxt = IDLE;
        else if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // new events use the old mask and beat the dispatch clear
    pend_nxt = pend_nxt | (bus.irq & mask_q);
    if (bus.mask_we) begin
      mask_nxt = bus.din[6:0];
      pend_nxt = pend_nxt & bus.din[6:0];
    end
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      pend_q <= 7'd0;
      mask_q <= 7'd0;
      vect_q <= 3'd0;
      intr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      mask_q <= mask_nxt;
      vect_q <= vect_nxt;
      intr_q <= intr_nxt;
    end
  end

`ifdef IRQ_CTRL_TIMEOUT_EN
  logic [15:0] cnt;
  logic        tmo_q;

  assign expire = (state == WAIT_ACK) &&
                  (cnt == 16'(TIMEOUT - 1));

  // ack watchdog, restarted on every dispatch
  always_ff @(posedge clock) begin
    if (!reset_n)               cnt <= 16'd0;
    else if (state == DISPATCH) cnt <= 16'd0;
    else if (state == WAIT_ACK) cnt <= cnt + 16'd1;
  end

  // sticky timeout flag, cleared by any ack
  always_ff @(posedge clock) begin
    if (!reset_n)        tmo_q <= 1'b0;
    else if (bus.ack_we) tmo_q <= 1'b0;
    else if (expire)     tmo_q <= 1'b1;
  end

  assign bus.tmo = tmo_q;
`else
  assign expire  = 1'b0;
  assign bus.tmo = 1'b0;
`endif

  assign bus.intr    = intr_q;
  assign bus.vect    = vect_q;
  assign bus.pending = pend_q;
  assign bus.mask    = mask_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
// Timeout section active when IRQ_CTRL_TIMEOUT_EN is defined.
module tb_irq_ctrl;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  irq_ctrl_if bus ();

  irq_ctrl #(.TIMEOUT(8)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mask(input logic [7:0] d);
    bus.mask_we = 1'b1;
    bus.din     = d;
    tick();
    bus.mask_we = 1'b0;
    bus.din     = 8'h00;
  endtask

  task automatic pulse(input logic [6:0] v);
    bus.irq = v;
    tick();
    bus.irq = 7'h00;
  endtask

  task automatic ack();
    bus.ack_we = 1'b1;
    tick();
    bus.ack_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    bus.irq     = 7'h00;
    bus.mask_we = 1'b0;
    bus.ack_we  = 1'b0;
    bus.din     = 8'h00;
    tick();
    tick();
    chk("rst_intr", 8'(bus.intr), 8'h0);
    chk("rst_vect", 8'(bus.vect), 8'h0);
    chk("rst_pend", 8'(bus.pending), 8'h00);
    chk("rst_mask", 8'(bus.mask), 8'h00);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_tmo", 8'(bus.tmo), 8'h0);
    reset_n = 1'b1;

    // single source, 2-cycle latency
    set_mask(8'h03);
    chk("t1_mask", 8'(bus.mask), 8'h03);
    pulse(7'h01);
    chk("t1_latch", 8'(bus.pending), 8'h01);
    chk("t1_nointr", 8'(bus.intr), 8'h0);
    tick();
    chk("t1_intr", 8'(bus.intr), 8'h1);
    chk("t1_vect", 8'(bus.vect), 8'h1);
    chk("t1_busy", 8'(bus.busy), 8'h1);
    chk("t1_pend", 8'(bus.pending), 8'h00);
    tick();
    ack();
    chk("t1_idle", 8'(bus.busy), 8'h0);

    // two simultaneous sources, priority order
    do_reset();
    set_mask(8'h7F);
    pulse(7'h06);
    chk("t2_pend", 8'(bus.pending), 8'h06);
    tick();
    chk("t2_vect1", 8'(bus.vect), 8'h2);
    chk("t2_intr1", 8'(bus.intr), 8'h1);
    chk("t2_pend1", 8'(bus.pending), 8'h04);
    tick();
    tick();
    chk("t2_hold", 8'(bus.intr), 8'h1);
    chk("t2_wait", 8'(bus.busy), 8'h1);
    ack();
    tick();
    chk("t2_vect2", 8'(bus.vect), 8'h3);
    chk("t2_intr2", 8'(bus.intr), 8'h0);
    chk("t2_pend2", 8'(bus.pending), 8'h00);
    tick();
    ack();

    // masked-off pulse is dropped
    set_mask(8'h01);
    pulse(7'h02);
    chk("t3_pend", 8'(bus.pending), 8'h00);
    tick();
    tick();
    chk("t3_intr", 8'(bus.intr), 8'h0);
    chk("t3_busy", 8'(bus.busy), 8'h0);

    // mask write flushes pending
    set_mask(8'h7F);
    pulse(7'h01);
    tick();
    chk("t4_vect", 8'(bus.vect), 8'h1);
    tick();
    pulse(7'h04);
    chk("t4_pend", 8'(bus.pending), 8'h04);
    set_mask(8'h03);
    chk("t4_flush", 8'(bus.pending), 8'h00);
    chk("t4_mask", 8'(bus.mask), 8'h03);
    ack();
    tick();
    chk("t4_nodisp", 8'(bus.busy), 8'h0);
    chk("t4_intr", 8'(bus.intr), 8'h1);

    // pulse during dispatch clear keeps bit set
    set_mask(8'h7F);
    pulse(7'h01);
    pulse(7'h01);
    chk("t5_intr", 8'(bus.intr), 8'h0);
    chk("t5_setwin", 8'(bus.pending), 8'h01);
    tick();
    ack();
    tick();
    chk("t5_redisp", 8'(bus.intr), 8'h1);
    chk("t5_pend", 8'(bus.pending), 8'h00);
    tick();

    // reset during WAIT_ACK
    pulse(7'h10);
    chk("t6_pend", 8'(bus.pending), 8'h10);
    reset_n     = 1'b0;
    bus.irq     = 7'h7F;
    bus.ack_we  = 1'b1;
    tick();
    bus.irq     = 7'h00;
    bus.ack_we  = 1'b0;
    reset_n     = 1'b1;
    chk("t6_busy", 8'(bus.busy), 8'h0);
    chk("t6_pend0", 8'(bus.pending), 8'h00);
    chk("t6_intr", 8'(bus.intr), 8'h0);
    chk("t6_vect", 8'(bus.vect), 8'h0);

    // ack watchdog
    set_mask(8'h01);
    pulse(7'h01);
    tick();
    tick();
`ifdef IRQ_CTRL_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("t7_still", 8'(bus.busy), 8'h1);
    chk("t7_tmo0", 8'(bus.tmo), 8'h0);
    tick();
    chk("t7_rel", 8'(bus.busy), 8'h0);
    chk("t7_tmo1", 8'(bus.tmo), 8'h1);
    chk("t7_intr", 8'(bus.intr), 8'h1);
    ack();
    chk("t7_clr", 8'(bus.tmo), 8'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("t7_hold", 8'(bus.busy), 8'h1);
    chk("t7_tmo", 8'(bus.tmo), 8'h0);
    ack();
    chk("t7_rel", 8'(bus.busy), 8'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
